port_write_ctrl: RTL



---
 rtl/port_write_ctrl_if.sv | 11 +
 rtl/port_write_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/port_write_ctrl_if.sv
// CPU-side write bus of the 8255A write path: chip select, write strobe,
// register address and write data, all synchronous to the system clock.
interface port_write_ctrl_if;
  logic       cs_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] din;

  modport master (output cs_n, output wr_n, output addr, output din);
  modport slave  (input  cs_n, input  wr_n, input  addr, input  din);
endinterface

// File: rtl/port_write_ctrl.sv
// 8255A write path: captures CPU writes, commits them into the port A/B/C
// output latches, the control word and port C bit set/reset, and runs the
// mode 1 strobed-output handshake (OBF#/ACK#/INTR) for ports A and B.
module port_write_ctrl (
  input  logic                    clk,
  input  logic                    reset,
  port_write_ctrl_if.slave        bus,
  input  logic                    ack_a_n,
  input  logic                    ack_b_n,
  output logic [7:0]              pa_out,
  output logic [7:0]              pb_out,
  output logic [7:0]              pc_out,
  output logic                    pa_oe,
  output logic                    pb_oe,
  output logic [7:0]              pc_oe,
  output logic [6:0]              ctrl_word,
  output logic                    intr_a,
  output logic                    intr_b
);

  typedef enum logic {HS_IDLE = 1'b0, HS_FULL = 1'b1} hsState_t;

  logic       r_pending;
  logic [1:0] r_addr;
  logic [7:0] r_data;
  logic [6:0] r_ctrlWord;
  logic [7:0] r_paOut;
  logic [7:0] r_pbOut;
  logic [7:0] r_pcLatch;
  logic       r_inteA;
  logic       r_inteB;
  logic       r_intrA;
  logic       r_intrB;
  logic       r_ackAPrev;
  logic       r_ackBPrev;
  hsState_t   r_stateA;
  hsState_t   r_stateB;

  hsState_t   w_nextStateA;
  hsState_t   w_nextStateB;
  logic       w_obfAN;
  logic       w_obfBN;
  logic       w_commit;
  logic       w_commitPa;
  logic       w_commitPb;
  logic       w_commitPc;
  logic       w_modeSet;
  logic       w_bsr;
  logic [2:0] w_bsrBit;
  logic       w_modeA1;
  logic       w_modeB1;
  logic [7:0] w_hsMask;
  logic       w_ackAFall;
  logic       w_ackARise;
  logic       w_ackBFall;
  logic       w_ackBRise;

  // Decode the committed write and the current handshake modes
  always_comb begin
    w_commit   = bus.wr_n & r_pending;
    w_commitPa = w_commit & (r_addr == 2'b00);
    w_commitPb = w_commit & (r_addr == 2'b01);
    w_commitPc = w_commit & (r_addr == 2'b10);
    w_modeSet  = w_commit & (r_addr == 2'b11) &  r_data[7];
    w_bsr      = w_commit & (r_addr == 2'b11) & ~r_data[7];
    w_bsrBit   = r_data[3:1];
    w_modeA1   = (r_ctrlWord[6:5] == 2'b01) & ~r_ctrlWord[4];
    w_modeB1   = r_ctrlWord[2] & ~r_ctrlWord[1];
    w_hsMask   = 8'h00;
    if (w_modeA1) w_hsMask = w_hsMask | 8'b1100_1000;
    if (w_modeB1) w_hsMask = w_hsMask | 8'b0000_0111;
    w_ackAFall =  r_ackAPrev & ~ack_a_n;
    w_ackARise = ~r_ackAPrev &  ack_a_n;
    w_ackBFall =  r_ackBPrev & ~ack_b_n;
    w_ackBRise = ~r_ackBPrev &  ack_b_n;
  end

  // Capture a selected write while the strobe is low; a deselected low strobe
  // drops it, and the first high strobe after a capture consumes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_addr    <= 2'b00;
      r_data    <= 8'h00;
    end else if (!bus.wr_n) begin
      if (!bus.cs_n) begin
        r_pending <= 1'b1;
        r_addr    <= bus.addr;
        r_data    <= bus.din;
      end else begin
        r_pending <= 1'b0;
      end
    end else if (r_pending) begin
      r_pending <= 1'b0;
    end
  end

  // Control word: reset leaves every port as an input
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_ctrlWord <= 7'h1B;
    else if (w_modeSet) r_ctrlWord <= r_data[6:0];
  end

  // Port A and port B output latches, cleared by any mode set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_paOut <= 8'h00;
      r_pbOut <= 8'h00;
    end else if (w_modeSet) begin
      r_paOut <= 8'h00;
      r_pbOut <= 8'h00;
    end else begin
      if (w_commitPa) r_paOut <= r_data;
      if (w_commitPb) r_pbOut <= r_data;
    end
  end

  // Port C latch: byte writes and bit set/reset leave handshake-owned bits alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcLatch <= 8'h00;
    end else if (w_modeSet) begin
      r_pcLatch <= 8'h00;
    end else if (w_commitPc) begin
      r_pcLatch <= (r_pcLatch & w_hsMask) | (r_data & ~w_hsMask);
    end else if (w_bsr && !w_hsMask[w_bsrBit]) begin
      r_pcLatch[w_bsrBit] <= r_data[0];
    end
  end

  // Interrupt enables live on the ACK bit positions while in mode 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inteA <= 1'b0;
      r_inteB <= 1'b0;
    end else if (w_modeSet) begin
      r_inteA <= 1'b0;
      r_inteB <= 1'b0;
    end else begin
      if (w_bsr && w_modeA1 && (w_bsrBit == 3'd6)) r_inteA <= r_data[0];
      if (w_bsr && w_modeB1 && (w_bsrBit == 3'd2)) r_inteB <= r_data[0];
    end
  end

  // Previous ACK samples for edge detection; inputs are already synchronous
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ackAPrev <= 1'b0;
      r_ackBPrev <= 1'b0;
    end else begin
      r_ackAPrev <= ack_a_n;
      r_ackBPrev <= ack_b_n;
    end
  end

  // Handshake state registers for ports A and B
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stateA <= HS_IDLE;
      r_stateB <= HS_IDLE;
    end else begin
      r_stateA <= w_nextStateA;
      r_stateB <= w_nextStateB;
    end
  end

  // Port A next state: a commit fills the buffer and wins over a same-edge ACK fall
  always_comb begin
    w_nextStateA = r_stateA;
    if (w_modeSet) begin
      w_nextStateA = HS_IDLE;
    end else if (w_modeA1) begin
      if (w_commitPa)                                w_nextStateA = HS_FULL;
      else if ((r_stateA == HS_FULL) && w_ackAFall)  w_nextStateA = HS_IDLE;
    end
  end

  // Port B next state, same rules as port A
  always_comb begin
    w_nextStateB = r_stateB;
    if (w_modeSet) begin
      w_nextStateB = HS_IDLE;
    end else if (w_modeB1) begin
      if (w_commitPb)                                w_nextStateB = HS_FULL;
      else if ((r_stateB == HS_FULL) && w_ackBFall)  w_nextStateB = HS_IDLE;
    end
  end

  // OBF# is low exactly while the output buffer is full
  always_comb begin
    w_obfAN = 1'b1;
    w_obfBN = 1'b1;
    if (r_stateA == HS_FULL) w_obfAN = 1'b0;
    if (r_stateB == HS_FULL) w_obfBN = 1'b0;
  end

  // Interrupt requests: set by an ACK rise on an empty buffer, cleared by a new write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_intrA <= 1'b0;
      r_intrB <= 1'b0;
    end else if (w_modeSet) begin
      r_intrA <= 1'b0;
      r_intrB <= 1'b0;
    end else begin
      if (w_modeA1) begin
        if (w_commitPa)
          r_intrA <= 1'b0;
        else if ((r_stateA == HS_IDLE) && w_ackARise && r_inteA)
          r_intrA <= 1'b1;
      end
      if (w_modeB1) begin
        if (w_commitPb)
          r_intrB <= 1'b0;
        else if ((r_stateB == HS_IDLE) && w_ackBRise && r_inteB)
          r_intrB <= 1'b1;
      end
    end
  end

  // Port C drive value and enables, with handshake pins overriding the latch
  always_comb begin
    pc_out = r_pcLatch;
    pc_oe  = {{4{~r_ctrlWord[3]}}, {4{~r_ctrlWord[0]}}};
    if (w_modeA1) begin
      pc_out[7] = w_obfAN;
      pc_out[3] = r_intrA;
      pc_oe[7]  = 1'b1;
      pc_oe[3]  = 1'b1;
      pc_oe[6]  = 1'b0;
    end
    if (w_modeB1) begin
      pc_out[1] = w_obfBN;
      pc_out[0] = r_intrB;
      pc_oe[1]  = 1'b1;
      pc_oe[0]  = 1'b1;
      pc_oe[2]  = 1'b0;
    end
  end

  // Remaining outputs come straight from the registers
  always_comb begin
    pa_out    = r_paOut;
    pb_out    = r_pbOut;
    pa_oe     = ~r_ctrlWord[4];
    pb_oe     = ~r_ctrlWord[1];
    ctrl_word = r_ctrlWord;
    intr_a    = r_intrA;
    intr_b    = r_intrB;
  end

endmodule
